// File: rtl/mem_arbiter_if.sv
// Signal bundle for mem_arbiter: instruction-fetch port, data port and the shared memory port.
// master is the arbiter's own view; slave is the view of the requesters and memory around it.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;

  logic        dm_req;
  logic        dm_we;
  logic [1:0]  dm_size;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        timeout_err;

  modport master (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_size, dm_addr, dm_wdata,
    input  mem_ack, mem_rdata,
    output if_ack, if_rdata,
    output dm_ack, dm_rdata,
    output mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    output timeout_err
  );

  modport slave (
    output if_req, if_addr,
    output dm_req, dm_we, dm_size, dm_addr, dm_wdata,
    output mem_ack, mem_rdata,
    input  if_ack, if_rdata,
    input  dm_ack, dm_rdata,
    input  mem_req, mem_we, mem_size, mem_addr, mem_wdata,
    input  timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one memory port between instruction fetch and data access.
// Data wins by default; fetch is forced through after STARVE_LIMIT back-to-back data grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int TIMEOUT      = 64
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);

  localparam int STARVE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_IF = 2'd1,
    GRANT_DM = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [STARVE_W-1:0] starve_cnt;
  logic [STARVE_W-1:0] starve_next;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WAIT_W-1:0]   wait_next;
  logic                grant_if;
  logic                grant_dm;
  logic                timed_out;
  logic                access_done;

  logic                cmd_we;
  logic [1:0]          cmd_size;
  logic [31:0]         cmd_addr;
  logic [31:0]         cmd_wdata;
  logic                err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wait_cnt   <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_next;
      wait_cnt   <= wait_next;
    end
  end

  // Arbitration happens only in IDLE, so every access is followed by at least one IDLE cycle.
  always_comb begin
    state_next  = state;
    starve_next = starve_cnt;
    wait_next   = wait_cnt;
    grant_if    = 1'b0;
    grant_dm    = 1'b0;
    timed_out   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.dm_req && (!bus.if_req || (starve_cnt < STARVE_MAX))) begin
          grant_dm   = 1'b1;
          state_next = GRANT_DM;
          wait_next  = '0;
          if (!bus.if_req) begin
            starve_next = '0;
          end else if (starve_cnt != STARVE_MAX) begin
            starve_next = starve_cnt + 1'b1;
          end
        end else if (bus.if_req) begin
          grant_if    = 1'b1;
          state_next  = GRANT_IF;
          wait_next   = '0;
          starve_next = '0;
        end
      end
      GRANT_IF, GRANT_DM: begin
        if (bus.mem_ack) begin
          state_next = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          timed_out  = 1'b1;
          state_next = IDLE;
        end else begin
          wait_next = wait_cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The command is latched at grant time so requester changes during the access are invisible.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_we    <= 1'b0;
      cmd_size  <= 2'b00;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      err_q     <= 1'b0;
    end else begin
      if (grant_dm) begin
        cmd_we    <= bus.dm_we;
        cmd_size  <= bus.dm_size;
        cmd_addr  <= bus.dm_addr;
        cmd_wdata <= bus.dm_wdata;
      end else if (grant_if) begin
        cmd_we    <= 1'b0;
        cmd_size  <= 2'b10;
        cmd_addr  <= bus.if_addr;
        cmd_wdata <= '0;
      end else if (state_next == IDLE) begin
        cmd_we    <= 1'b0;
      end
      if (timed_out) begin
        err_q <= 1'b1;
      end
    end
  end

  // A reset landing mid-access kills the ack, so the requester never sees a half-finished transfer.
  always_comb begin
    access_done = (bus.mem_ack || timed_out) && !rst;
  end

  assign bus.if_ack      = (state == GRANT_IF) && access_done;
  assign bus.dm_ack      = (state == GRANT_DM) && access_done;
  assign bus.if_rdata    = ((state == GRANT_IF) && !timed_out) ? bus.mem_rdata : 32'h0;
  assign bus.dm_rdata    = ((state == GRANT_DM) && !timed_out) ? bus.mem_rdata : 32'h0;

  assign bus.mem_req     = (state != IDLE);
  assign bus.mem_we      = cmd_we;
  assign bus.mem_size    = cmd_size;
  assign bus.mem_addr    = cmd_addr;
  assign bus.mem_wdata   = cmd_wdata;
  assign bus.timeout_err = err_q;

endmodule
